// File: rtl/uart_tx_if.sv
// Host-side byte stream for uart_tx: char/tx_valid offered by the host,
// tx_ready returned by the transmitter; a transfer is tx_valid & tx_ready.
interface uart_tx_if;
  logic [7:0] char;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output char,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  char,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (start, 8 data bits LSB-first, STOP_BITS stop bits).
// Define UART_TX_FIFO_EN to replace the one-byte holding register by a FIFO_DEPTH-entry FIFO.
module uart_tx #(
  parameter int CLKS_PER_BIT = 32,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tx_en,
  uart_tx_if.slave host,
  output logic     tx,
  output logic     busy,
  output logic     done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]   bit_idx;
  logic [2:0]   bit_next;
  logic         stop_idx;
  logic         stop_next;
  logic [7:0]   shift;
  logic [7:0]   shift_next;
  logic         tx_next;
  logic         cnt_last;
  logic         load;
  logic         push;
  logic         have_byte;
  logic [7:0]   head;

  assign push = host.tx_valid & host.tx_ready;

`ifdef UART_TX_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign have_byte     = (count != '0);
  assign head          = mem[rd_ptr];
  assign host.tx_ready = ~rst & (count != FULL_COUNT);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= host.char;
    end
  end

  // A pop only ever takes a byte that was already stored before this edge,
  // so push-while-empty and pop never act on the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  assign have_byte     = hold_valid;
  assign head          = hold_data;
  assign host.tx_ready = ~rst & ~hold_valid;

  // Ready is low while the holding register is full, so push and load never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= host.char;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    stop_next  = stop_idx;
    shift_next = shift;
    load       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    tx_next    = 1'b1;
    cnt_last   = (cnt == CNT_LAST);

    case (state)
      IDLE: begin
        if (tx_en && have_byte) begin
          state_next = START;
          load       = 1'b1;
          shift_next = head;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_last) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            stop_next  = 1'b0;
          end else begin
            bit_next   = bit_idx + 3'd1;
            shift_next = shift >> 1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (stop_idx == STOP_LAST) begin
            // Chain straight into the next start bit when a byte is waiting.
            if (tx_en && have_byte) begin
              state_next = START;
              load       = 1'b1;
              shift_next = head;
            end else begin
              state_next = IDLE;
            end
          end else begin
            stop_next = stop_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase

    busy = ~rst & (state != IDLE);
    done = ~rst & (state == STOP) & cnt_last & (stop_idx == STOP_LAST);
  end

  // tx is driven from the next-state view so the line changes on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      cnt      <= cnt_next;
      bit_idx  <= bit_next;
      stop_idx <= stop_next;
      shift    <= shift_next;
      tx       <= tx_next;
    end
  end

endmodule
